// File: rtl/envelope_vca.sv
// envelope_vca: ADSR envelope generator driving an 8-bit VCA
// on the offset-binary audio stream from the waveform mixer.
module envelope_vca #(
  parameter int PRESCALE = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gate,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  input  logic [7:0] audio_in,
  output logic [7:0] audio_out,
  output logic [7:0] envelope_out,
  output logic [2:0] state_out,
  output logic       busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e        state_q;
  logic [15:0]   env_q;
  logic [PW-1:0] pre_q;
  logic [7:0]    audio_q;
  logic          tick;

  logic [16:0] step_a, step_d, step_r;
  logic [16:0] env_x, sus_t, att_sum, dec_lim;

  function automatic logic [16:0] step(input logic [7:0] rate);
    return ({9'b0, rate} << 4) + 17'd16;
  endfunction

  assign tick    = (pre_q == PMAX);
  assign step_a  = step(attack_rate);
  assign step_d  = step(decay_rate);
  assign step_r  = step(release_rate);
  assign env_x   = {1'b0, env_q};
  assign sus_t   = {1'b0, sustain_level, 8'h00};
  assign att_sum = env_x + step_a;
  assign dec_lim = sus_t + step_d;

  // free-running tick prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

  // ADSR sequencer: gate edges win over tick stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      env_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gate) state_q <= ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state_q <= RELEASE;
          end else if (tick) begin
            if (att_sum >= 17'h0FFFF) begin
              env_q   <= 16'hFFFF;
              state_q <= DECAY;
            end else begin
              env_q <= att_sum[15:0];
            end
          end
        end
        DECAY: begin
          if (!gate) begin
            state_q <= RELEASE;
          end else if (tick) begin
            if (env_x <= dec_lim) begin
              env_q   <= sus_t[15:0];
              state_q <= SUSTAIN;
            end else begin
              env_q <= env_q - step_d[15:0];
            end
          end
        end
        SUSTAIN: begin
          if (!gate) begin
            state_q <= RELEASE;
          end else if (tick) begin
            env_q <= sus_t[15:0];
          end
        end
        RELEASE: begin
          if (gate) begin
            state_q <= ATTACK;
          end else if (tick) begin
            if (env_x <= step_r) begin
              env_q   <= '0;
              state_q <= IDLE;
            end else begin
              env_q <= env_q - step_r[15:0];
            end
          end
        end
        default: begin
          state_q <= IDLE;
          env_q   <= '0;
        end
      endcase
    end
  end

  logic signed [8:0]  s_w;
  logic signed [17:0] s_ext, e_ext, p_w, r_w;
  logic [7:0]         audio_d;

  assign s_w   = $signed({1'b0, audio_in}) - 9'sd128;
  assign s_ext = {{9{s_w[8]}}, s_w};
  assign e_ext = {10'b0, env_q[15:8]};
  assign p_w   = s_ext * e_ext;
  assign r_w   = (p_w >>> 8) + 18'sd128;

  // clamp the recentred product into the 8-bit sample range
  always_comb begin
    audio_d = r_w[7:0];
    if (r_w < 0) begin
      audio_d = 8'h00;
    end else if (r_w > 18'sd255) begin
      audio_d = 8'hFF;
    end
  end

  // register the VCA result using the pre-edge envelope
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_q <= 8'h80;
    end else begin
      audio_q <= audio_d;
    end
  end

  assign audio_out    = audio_q;
  assign envelope_out = env_q[15:8];
  assign state_out    = state_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_envelope_vca.sv
// tb_envelope_vca: directed checks of the ADSR sequencer,
// retrigger, early release, VCA math and prescaled sustain.
module tb_envelope_vca;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       gate = 1'b0;
  logic [7:0] ar = '0, dr = '0, sl = '0, rr = '0;
  logic [7:0] ain = 8'h80;
  logic [7:0] aout, eout;
  logic [2:0] sout;
  logic       busy;

  logic       gate_b = 1'b0;
  logic [7:0] ar_b = '0, dr_b = '0, sl_b = '0, rr_b = '0;
  logic [7:0] ain_b = 8'h80;
  logic [7:0] aout_b, eout_b;
  logic [2:0] sout_b;
  logic       busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  envelope_vca #(.PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .attack_rate(ar), .decay_rate(dr),
    .sustain_level(sl), .release_rate(rr),
    .audio_in(ain), .audio_out(aout),
    .envelope_out(eout), .state_out(sout), .busy(busy)
  );

  envelope_vca #(.PRESCALE(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .gate(gate_b),
    .attack_rate(ar_b), .decay_rate(dr_b),
    .sustain_level(sl_b), .release_rate(rr_b),
    .audio_in(ain_b), .audio_out(aout_b),
    .envelope_out(eout_b), .state_out(sout_b), .busy(busy_b)
  );

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    gate = 1'b0;
    gate_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    gate = 1'b1;
    ain = 8'hFF;
    rst_n = 1'b0;
    #1;
    checks++;
    if (aout !== 8'h80) begin
      errors++;
      $display("FAIL rst_audio got %h want 80", aout);
    end
    checks++;
    if (eout !== 8'h00) begin
      errors++;
      $display("FAIL rst_env got %h want 00", eout);
    end
    checks++;
    if (sout !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_state got %0d/%b want 0/0", sout, busy);
    end
    @(negedge clk);
    checks++;
    if (aout !== 8'h80 || aout_b !== 8'h80 || eout_b !== 8'h00) begin
      errors++;
      $display("FAIL rst_hold got %h/%h/%h want 80/80/00",
               aout, aout_b, eout_b);
    end
    rst_n = 1'b1;
    tick_n(1);
    checks++;
    if (sout !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_gate got %0d/%b want 1/1", sout, busy);
    end
    ain = 8'h80;
  endtask

  task automatic test_full_adsr();
    do_reset();
    ar = 8'hFF; dr = 8'hFF; sl = 8'h80; rr = 8'h00;
    gate = 1'b1;
    tick_n(1);
    checks++;
    if (sout !== 3'd1 || eout !== 8'h00) begin
      errors++;
      $display("FAIL adsr_enter got %0d/%h want 1/00", sout, eout);
    end
    tick_n(15);
    checks++;
    if (sout !== 3'd1 || eout !== 8'hF0) begin
      errors++;
      $display("FAIL adsr_att15 got %0d/%h want 1/f0", sout, eout);
    end
    tick_n(1);
    checks++;
    if (sout !== 3'd2 || eout !== 8'hFF) begin
      errors++;
      $display("FAIL adsr_peak got %0d/%h want 2/ff", sout, eout);
    end
    tick_n(7);
    checks++;
    if (sout !== 3'd2 || eout !== 8'h8F) begin
      errors++;
      $display("FAIL adsr_dec7 got %0d/%h want 2/8f", sout, eout);
    end
    tick_n(1);
    checks++;
    if (sout !== 3'd3 || eout !== 8'h80) begin
      errors++;
      $display("FAIL adsr_sus got %0d/%h want 3/80", sout, eout);
    end
    gate = 1'b0;
    tick_n(1);
    checks++;
    if (sout !== 3'd4 || eout !== 8'h80 || busy !== 1'b1) begin
      errors++;
      $display("FAIL adsr_rel got %0d/%h/%b want 4/80/1",
               sout, eout, busy);
    end
    tick_n(1024);
    checks++;
    if (sout !== 3'd4 || eout !== 8'h40) begin
      errors++;
      $display("FAIL adsr_rel1024 got %0d/%h want 4/40", sout, eout);
    end
    tick_n(1023);
    checks++;
    if (sout !== 3'd4 || eout !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL adsr_rel2047 got %0d/%h/%b want 4/00/1",
               sout, eout, busy);
    end
    tick_n(1);
    checks++;
    if (sout !== 3'd0 || eout !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL adsr_idle got %0d/%h/%b want 0/00/0",
               sout, eout, busy);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    ar = 8'hFF; dr = 8'hFF; sl = 8'h80; rr = 8'h00;
    gate = 1'b1;
    tick_n(25);
    gate = 1'b0;
    tick_n(1025);
    checks++;
    if (sout !== 3'd4 || eout !== 8'h40) begin
      errors++;
      $display("FAIL retrig_rel got %0d/%h want 4/40", sout, eout);
    end
    gate = 1'b1;
    tick_n(1);
    checks++;
    if (sout !== 3'd1 || eout !== 8'h40) begin
      errors++;
      $display("FAIL retrig_att got %0d/%h want 1/40", sout, eout);
    end
    tick_n(11);
    checks++;
    if (sout !== 3'd1 || eout !== 8'hF0) begin
      errors++;
      $display("FAIL retrig_att11 got %0d/%h want 1/f0", sout, eout);
    end
    tick_n(1);
    checks++;
    if (sout !== 3'd2 || eout !== 8'hFF) begin
      errors++;
      $display("FAIL retrig_dec got %0d/%h want 2/ff", sout, eout);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    ar = 8'h00; rr = 8'hFF;
    gate = 1'b1;
    tick_n(4);
    checks++;
    if (sout !== 3'd1 || eout !== 8'h00) begin
      errors++;
      $display("FAIL early_att got %0d/%h want 1/00", sout, eout);
    end
    gate = 1'b0;
    tick_n(1);
    checks++;
    if (sout !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_rel got %0d/%b want 4/1", sout, busy);
    end
    tick_n(1);
    checks++;
    if (sout !== 3'd0 || busy !== 1'b0 || eout !== 8'h00) begin
      errors++;
      $display("FAIL early_idle got %0d/%b/%h want 0/0/00",
               sout, busy, eout);
    end
  endtask

  task automatic test_vca();
    logic [7:0] vin [5];
    logic [7:0] vexp [5];
    logic [7:0] prev;
    vin  = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'hFF};
    vexp = '{8'h00, 8'h40, 8'h80, 8'hBF, 8'hFE};
    do_reset();
    ar = 8'hFF; dr = 8'hFF; sl = 8'hFF;
    ain = 8'h80;
    gate = 1'b1;
    tick_n(18);
    checks++;
    if (sout !== 3'd3 || eout !== 8'hFF) begin
      errors++;
      $display("FAIL vca_sus got %0d/%h want 3/ff", sout, eout);
    end
    prev = 8'h80;
    for (int i = 0; i < 5; i++) begin
      ain = vin[i];
      #1;
      checks++;
      if (aout !== prev) begin
        errors++;
        $display("FAIL vca_lat%0d got %h want %h", i, aout, prev);
      end
      @(negedge clk);
      checks++;
      if (aout !== vexp[i]) begin
        errors++;
        $display("FAIL vca_full%0d in %h got %h want %h",
                 i, vin[i], aout, vexp[i]);
      end
      prev = vexp[i];
    end
    sl = 8'h00;
    tick_n(2);
    checks++;
    if (eout !== 8'h00) begin
      errors++;
      $display("FAIL vca_zero_env got %h want 00", eout);
    end
    for (int i = 0; i < 5; i++) begin
      ain = vin[i];
      tick_n(1);
      checks++;
      if (aout !== 8'h80) begin
        errors++;
        $display("FAIL vca_mute%0d in %h got %h want 80",
                 i, vin[i], aout);
      end
    end
    ain = 8'h80;
  endtask

  task automatic test_sustain_prescale();
    int n;
    bit hit;
    do_reset();
    ar_b = 8'hFF; dr_b = 8'hFF; sl_b = 8'h80;
    gate_b = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (sout_b == 3'd3) hit = 1'b1;
    end
    checks++;
    if (!hit || eout_b !== 8'h80) begin
      errors++;
      $display("FAIL pre_sus got %0d/%h want 3/80", sout_b, eout_b);
    end
    sl_b = 8'h20;
    n = 0;
    hit = 1'b0;
    for (int i = 1; i <= 8 && !hit; i++) begin
      @(negedge clk);
      if (eout_b == 8'h20) begin
        hit = 1'b1;
        n = i;
      end
    end
    checks++;
    if (!hit || n > 4) begin
      errors++;
      $display("FAIL pre_change got %0d clocks want 1..4", n);
    end
    sl_b = 8'h80;
    tick_n(3);
    checks++;
    if (eout_b !== 8'h20) begin
      errors++;
      $display("FAIL pre_between got %h want 20", eout_b);
    end
    tick_n(1);
    checks++;
    if (eout_b !== 8'h80) begin
      errors++;
      $display("FAIL pre_next_tick got %h want 80", eout_b);
    end
  endtask

  initial begin
    test_reset();
    test_full_adsr();
    test_retrigger();
    test_early_release();
    test_vca();
    test_sustain_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
